// File: rtl/oserdes_link_sched.sv
// oserdes_link_sched: bring-up sequencer and word scheduler feeding a 10:1
// DDR output serializer. Holds the serializer in reset until the clock source
// is locked, flushes it with idle words, sends a training burst, then streams
// upstream words with idle-word insertion when upstream has nothing ready.
module oserdes_link_sched #(
  parameter int          RST_CYCLES   = 4,
  parameter int          FLUSH_CYCLES = 8,
  parameter int          TRAIN_LEN    = 64,
  parameter logic [9:0]  TRAIN_WORD   = 10'h3E0,
  parameter logic [9:0]  IDLE_WORD    = 10'h000
) (
  input  logic        clk_div,
  input  logic        rst,
  input  logic        pll_locked,
  input  logic        retrain,
  input  logic [9:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [9:0]  data_out,
  output logic        serdes_rst,
  output logic        link_up,
  output logic [15:0] underflow_cnt
);

  typedef enum logic [1:0] {
    S_RST   = 2'd0,
    S_FLUSH = 2'd1,
    S_TRAIN = 2'd2,
    S_RUN   = 2'd3
  } state_t;

  // Last count value of each timed phase (count runs 0..N-1).
  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] FLUSH_LAST = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] TRAIN_LAST = 16'(TRAIN_LEN - 1);

  state_t      state_r;
  state_t      state_nx_s;
  logic [15:0] cnt_r;
  logic        hs_s;
  logic        idle_ins_s;
  logic [9:0]  word_nx_s;

  // A word is taken whenever the registered ready meets upstream valid.
  assign hs_s = s_valid & s_ready;

  // Next-state selection; lock loss outranks retrain and phase completion.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      S_RST: begin
        if (pll_locked && (cnt_r == RST_LAST)) state_nx_s = S_FLUSH;
        else                                   state_nx_s = S_RST;
      end
      S_FLUSH: begin
        if (!pll_locked)               state_nx_s = S_RST;
        else if (cnt_r == FLUSH_LAST)  state_nx_s = S_TRAIN;
        else                           state_nx_s = S_FLUSH;
      end
      S_TRAIN: begin
        if (!pll_locked)               state_nx_s = S_RST;
        else if (cnt_r == TRAIN_LAST)  state_nx_s = S_RUN;
        else                           state_nx_s = S_TRAIN;
      end
      S_RUN: begin
        if (!pll_locked)  state_nx_s = S_RST;
        else if (retrain) state_nx_s = S_TRAIN;
        else              state_nx_s = S_RUN;
      end
      default: state_nx_s = S_RST;
    endcase
  end

  // Word for the next cycle follows the next state; a word accepted on the
  // edge that leaves RUN is dropped in favour of the next state's word.
  always_comb begin
    word_nx_s  = IDLE_WORD;
    idle_ins_s = 1'b0;
    case (state_nx_s)
      S_RST:   word_nx_s = IDLE_WORD;
      S_FLUSH: word_nx_s = IDLE_WORD;
      S_TRAIN: word_nx_s = TRAIN_WORD;
      S_RUN: begin
        if (hs_s) begin
          word_nx_s  = s_data;
        end else begin
          word_nx_s  = IDLE_WORD;
          // The hand-over edge from training is not an underflow.
          idle_ins_s = (state_r == S_RUN);
        end
      end
      default: word_nx_s = IDLE_WORD;
    endcase
  end

  // State, phase counter and all registered outputs.
  always_ff @(posedge clk_div) begin
    if (rst) begin
      state_r       <= S_RST;
      cnt_r         <= 16'd0;
      serdes_rst    <= 1'b1;
      s_ready       <= 1'b0;
      link_up       <= 1'b0;
      data_out      <= IDLE_WORD;
      underflow_cnt <= 16'd0;
    end else begin
      state_r <= state_nx_s;
      if (state_nx_s != state_r) begin
        cnt_r <= 16'd0;
      end else if ((state_r == S_RST) && !pll_locked) begin
        cnt_r <= 16'd0;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
      serdes_rst <= (state_nx_s == S_RST);
      s_ready    <= (state_nx_s == S_RUN);
      link_up    <= (state_nx_s == S_RUN);
      data_out   <= word_nx_s;
      if (idle_ins_s && (underflow_cnt != 16'hFFFF)) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end else begin
        underflow_cnt <= underflow_cnt;
      end
    end
  end

endmodule

// File: tb/tb_oserdes_link_sched.sv
// Self-checking bench for oserdes_link_sched. The reference model tracks the
// link as a timeline position since the last restart plus a "running" flag,
// and is checked against the DUT after every clock edge.
module tb_oserdes_link_sched;

  localparam int         RST_C   = 4;
  localparam int         FLUSH_C = 8;
  localparam int         TRAIN_C = 64;
  localparam int         TOTAL_C = RST_C + FLUSH_C + TRAIN_C;
  localparam logic [9:0] TRAIN_W = 10'h3E0;
  localparam logic [9:0] IDLE_W  = 10'h000;

  logic        clk_div;
  logic        rst;
  logic        pll_locked;
  logic        retrain;
  logic [9:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [9:0]  data_out;
  logic        serdes_rst;
  logic        link_up;
  logic [15:0] underflow_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_t;
  bit         m_run;
  logic [9:0] m_data;
  int         m_uf;

  oserdes_link_sched #(
    .RST_CYCLES(RST_C), .FLUSH_CYCLES(FLUSH_C), .TRAIN_LEN(TRAIN_C),
    .TRAIN_WORD(TRAIN_W), .IDLE_WORD(IDLE_W)
  ) dut (
    .clk_div(clk_div), .rst(rst), .pll_locked(pll_locked), .retrain(retrain),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .data_out(data_out),
    .serdes_rst(serdes_rst), .link_up(link_up), .underflow_cnt(underflow_cnt)
  );

  initial clk_div = 1'b0;
  always #5 clk_div = ~clk_div;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs the DUT sampled.
  task automatic model_update();
    if (rst) begin
      m_t = 0; m_run = 1'b0; m_data = IDLE_W; m_uf = 0;
    end else if (!pll_locked) begin
      m_t = 0; m_run = 1'b0; m_data = IDLE_W;
    end else if (m_run) begin
      if (retrain) begin
        m_run = 1'b0; m_t = RST_C + FLUSH_C; m_data = TRAIN_W;
      end else if (s_valid) begin
        m_data = s_data;
      end else begin
        m_data = IDLE_W;
        if (m_uf < 65535) m_uf++;
      end
    end else begin
      m_t++;
      if (m_t >= TOTAL_C) begin
        m_run = 1'b1; m_data = IDLE_W;
      end else if (m_t >= RST_C + FLUSH_C) begin
        m_data = TRAIN_W;
      end else begin
        m_data = IDLE_W;
      end
    end
  endtask

  task automatic compare();
    chk("serdes_rst", 32'(serdes_rst), 32'(!m_run && (m_t < RST_C)));
    chk("s_ready", 32'(s_ready), 32'(m_run));
    chk("link_up", 32'(link_up), 32'(m_run));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("underflow_cnt", 32'(underflow_cnt), 32'(m_uf));
  endtask

  // One clock: inputs already set (at negedge), model follows the edge,
  // outputs compared on the falling edge.
  task automatic step();
    @(posedge clk_div);
    model_update();
    @(negedge clk_div);
    compare();
  endtask

  // Step until link_up appears; returns number of edges taken.
  task automatic wait_link(output int n);
    n = 0;
    while (!link_up && n < 300) begin
      step();
      n++;
    end
    if (!link_up) begin
      errors++;
      checks++;
      $display("FAIL wait_link actual=timeout required=link_up");
    end
  endtask

  int n, srst_n, idle_n, train_n, first_link;
  bit early_ready;

  initial begin
    rst = 1'b1; pll_locked = 1'b0; retrain = 1'b0; s_valid = 1'b0; s_data = 10'd0;
    m_t = 0; m_run = 1'b0; m_data = IDLE_W; m_uf = 0;
    @(negedge clk_div);
    for (int i = 0; i < 5; i++) step();

    // Bring-up: cycle 0 is the cycle in which rst is first low.
    rst = 1'b0; pll_locked = 1'b1;
    srst_n = 0; idle_n = 0; train_n = 0; first_link = -1; early_ready = 1'b0;
    for (int k = 0; k < 300 && first_link < 0; k++) begin
      if (link_up) first_link = k;
      else begin
        if (s_ready) early_ready = 1'b1;
        if (serdes_rst) srst_n++;
        else if (data_out == IDLE_W) idle_n++;
        else if (data_out == TRAIN_W) train_n++;
        step();
      end
    end
    chk("bringup_srst_cycles", 32'(srst_n), 32'd4);
    chk("bringup_flush_cycles", 32'(idle_n), 32'd8);
    chk("bringup_train_cycles", 32'(train_n), 32'd64);
    chk("bringup_link_cycle", 32'(first_link), 32'd76);
    chk("bringup_no_early_ready", 32'(early_ready), 32'd0);

    // Continuous stream 0..1023.
    s_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      s_data = 10'(i);
      step();
    end
    chk("stream_underflow", 32'(underflow_cnt), 32'd0);

    // 1-on/1-off idle insertion.
    for (int i = 0; i < 100; i++) begin
      s_valid = (i % 2 == 0);
      s_data = 10'($urandom);
      step();
    end
    chk("alt_underflow", 32'(underflow_cnt), 32'd50);

    // Retrain together with a valid word.
    s_valid = 1'b1; s_data = 10'h155; retrain = 1'b1;
    step();
    retrain = 1'b0;
    train_n = 0;
    for (int i = 0; i < 200 && !link_up; i++) begin
      if (!s_ready && data_out == TRAIN_W) train_n++;
      step();
    end
    chk("retrain_train_cycles", 32'(train_n), 32'd64);

    // Lock loss in RUN, then retrain pulse during flush (ignored).
    pll_locked = 1'b0;
    step();
    chk("lockloss_run_srst", 32'(serdes_rst), 32'd1);
    chk("lockloss_run_link", 32'(link_up), 32'd0);
    pll_locked = 1'b1;
    for (int i = 0; i < 6; i++) step();
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    wait_link(n);
    chk("flush_retrain_ignored", 32'(n + 7), 32'd76);

    // Lock loss in TRAIN.
    retrain = 1'b1; step(); retrain = 1'b0;
    for (int i = 0; i < 10; i++) step();
    pll_locked = 1'b0;
    step();
    chk("lockloss_train_srst", 32'(serdes_rst), 32'd1);
    pll_locked = 1'b1;
    wait_link(n);
    chk("lockloss_train_relink", 32'(n), 32'd76);

    // Lock held low for 20 cycles keeps the sequence frozen at its start.
    pll_locked = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("lock_low_srst", 32'(serdes_rst), 32'd1);
    pll_locked = 1'b1;
    wait_link(n);
    chk("lock_low_relink", 32'(n), 32'd76);

    // Randomized traffic with occasional retrain and lock glitches.
    for (int i = 0; i < 2000; i++) begin
      s_valid    = ($urandom_range(3) != 0);
      s_data     = 10'($urandom);
      retrain    = ($urandom_range(63) == 0);
      pll_locked = ($urandom_range(255) != 0);
      step();
    end
    retrain = 1'b0; pll_locked = 1'b1;

    // Mid-operation reset with underflow_cnt at 7.
    rst = 1'b1; step(); rst = 1'b0;
    s_valid = 1'b0;
    wait_link(n);
    for (int i = 0; i < 7; i++) step();
    chk("pre_reset_underflow", 32'(underflow_cnt), 32'd7);
    rst = 1'b1; step();
    chk("midrst_underflow", 32'(underflow_cnt), 32'd0);
    chk("midrst_srst", 32'(serdes_rst), 32'd1);
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_link", 32'(link_up), 32'd0);
    rst = 1'b0;

    // Long idle stretch saturates the underflow counter.
    wait_link(n);
    for (int i = 0; i < 65540; i++) step();
    chk("underflow_saturated", 32'(underflow_cnt), 32'h0000FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
